// File: rtl/store_buffer.sv
// In-order store buffer: allocate, commit and drain to memory, with conflict detection.
// Define STORE_BUFFER_FWD_EN to forward data from the youngest covering entry.
module store_buffer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_resetn_i,
    input  logic        flush_i,
    input  logic        enqueue_en_i,
    input  logic [29:0] enqueue_address_i,
    input  logic [31:0] enqueue_data_i,
    input  logic [3:0]  enqueue_bm_i,
    input  logic        enqueue_io_i,
    input  logic [4:0]  enqueue_rob_i,
    output logic        enqueue_full_o,
    input  logic        commit_i,
    input  logic [29:0] conflict_address_i,
    input  logic [3:0]  conflict_bm_i,
    output logic        conflict_o,
    output logic        fwd_vld_o,
    output logic [31:0] fwd_data_o,
    output logic        mem_req_o,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_bm_o,
    output logic        mem_io_o,
    input  logic        mem_ack_i,
    output logic        sb_empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef logic [PW:0] ptr_t;
    typedef enum logic {StIdle, StReq} state_e;

    ptr_t   head_q, cmt_q, tail_q;
    ptr_t   cmt_d, tail_d, count;
    state_e state_q;
    logic   mem_req_q;
    logic   enq_ok, commit_ok;

    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0]  bm_q   [DEPTH];
    logic        io_q   [DEPTH];

    logic [PW-1:0] head_slot, tail_slot;

    // Commits retire strictly in order, so the ROB tag carries no extra information here.
    logic unused_rob;
    assign unused_rob = ^enqueue_rob_i;

    assign head_slot      = head_q[PW-1:0];
    assign tail_slot      = tail_q[PW-1:0];
    assign count          = tail_q - head_q;
    assign enqueue_full_o = (count == ptr_t'(DEPTH));
    assign enq_ok         = enqueue_en_i & ~enqueue_full_o & ~flush_i;
    assign commit_ok      = commit_i & (cmt_q != tail_q);

    always_comb begin
        cmt_d  = cmt_q + ptr_t'(commit_ok);
        tail_d = flush_i ? cmt_d : tail_q + ptr_t'(enq_ok);
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (enq_ok) begin
            addr_q[tail_slot] <= enqueue_address_i;
            data_q[tail_slot] <= enqueue_data_i;
            bm_q[tail_slot]   <= enqueue_bm_i;
            io_q[tail_slot]   <= enqueue_io_i;
        end
    end

    // Drain FSM: head only moves on an accepted ack, so flush never disturbs it.
    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            state_q   <= StIdle;
            head_q    <= '0;
            mem_req_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (head_q != cmt_q) begin
                        state_q   <= StReq;
                        mem_req_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (mem_ack_i) begin
                        state_q   <= StIdle;
                        head_q    <= head_q + ptr_t'(1);
                        mem_req_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (state_q == StIdle && head_q != cmt_q) begin
            mem_addr_o <= addr_q[head_slot];
            mem_data_o <= data_q[head_slot];
            mem_bm_o   <= bm_q[head_slot];
            mem_io_o   <= io_q[head_slot];
        end
    end

    assign mem_req_o  = mem_req_q;
    assign sb_empty_o = (head_q == tail_q) & ~mem_req_q;

    logic          hit;
    logic [PW-1:0] slot;
`ifdef STORE_BUFFER_FWD_EN
    logic [3:0]  yng_bm;
    logic [31:0] yng_data;
    logic        yng_io;
    logic        fwd;
`endif

    // Scan oldest to youngest so the last match wins as the youngest.
    always_comb begin
        hit  = 1'b0;
        slot = '0;
`ifdef STORE_BUFFER_FWD_EN
        yng_bm   = '0;
        yng_data = '0;
        yng_io   = 1'b0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = head_slot + i[PW-1:0];
            if (ptr_t'(i) < count && addr_q[slot] == conflict_address_i &&
                |(bm_q[slot] & conflict_bm_i)) begin
                hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                yng_bm   = bm_q[slot];
                yng_data = data_q[slot];
                yng_io   = io_q[slot];
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign fwd        = hit & ((yng_bm & conflict_bm_i) == conflict_bm_i) & ~yng_io;
    assign fwd_vld_o  = fwd;
    assign fwd_data_o = fwd ? yng_data : 32'h0;
    assign conflict_o = hit & ~fwd;
`else
    assign fwd_vld_o  = 1'b0;
    assign fwd_data_o = 32'h0;
    assign conflict_o = hit;
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, 4..16).
REQ-002 SHALL have ports: cpu_clock_i in 1 (clock, rising edge); cpu_resetn_i in 1 (async reset, active-low).
REQ-003 SHALL have ports: flush_i in 1 (discard uncommitted); enqueue_en_i in 1; enqueue_address_i in 30 (word address); enqueue_data_i in 32; enqueue_bm_i in 4; enqueue_io_i in 1; enqueue_rob_i in 5.
REQ-004 SHALL have port enqueue_full_o out 1 (buffer cannot accept).
REQ-005 SHALL have port commit_i in 1 (oldest uncommitted store retired).
REQ-006 SHALL have ports: conflict_address_i in 30; conflict_bm_i in 4; conflict_o out 1; fwd_vld_o out 1; fwd_data_o out 32.
REQ-007 SHALL have ports: mem_req_o out 1; mem_addr_o out 30; mem_data_o out 32; mem_bm_o out 4; mem_io_o out 1; mem_ack_i in 1.
REQ-008 SHALL have port sb_empty_o out 1 (no valid entries and no outstanding request).

Function
REQ-009 SHALL hold entries in a circular queue with pointers head (drain), cmt (commit boundary) and tail (alloc), each log2(DEPTH)+1 bits wide; the MSB is the wrap bit.
REQ-010 SHALL drive enqueue_full_o = (tail - head == DEPTH), from registers only.
REQ-011 SHALL write an entry at tail and increment tail on enqueue_en_i & !enqueue_full_o & !flush_i; enqueue while full or during flush SHALL be ignored.
REQ-012 SHALL advance cmt by one on commit_i when cmt != tail; commit_i with cmt == tail SHALL be ignored.
REQ-013 SHALL set tail <= cmt (post-commit value) on flush_i; commit_i in the same cycle SHALL take effect first.
REQ-014 SHALL leave committed entries (head..cmt) and the drain FSM unaffected by flush_i.
REQ-015 SHALL run a drain FSM with states IDLE and REQ.
REQ-016 SHALL, in IDLE with head != cmt, go to REQ next cycle with mem_* registered from the head entry and mem_req_o=1.
REQ-017 SHALL, in REQ, hold mem_* stable until mem_ack_i; on ack SHALL increment head, clear mem_req_o and go to IDLE; minimum spacing is 2 cycles per store.
REQ-018 SHALL assert conflict_o combinationally when any entry in head..tail (committed or not, including the one in REQ) has address == conflict_address_i and (bm & conflict_bm_i) != 0, subject to REQ-023.
REQ-019 SHALL treat io entries identically for conflicts.
REQ-020 SHALL drive sb_empty_o = (head == tail) & !mem_req_o.

Reset
REQ-021 SHALL, on cpu_resetn_i low, asynchronously clear head, cmt and tail, put the FSM in IDLE, and drive mem_req_o=0, enqueue_full_o=0, sb_empty_o=1, conflict_o=0, fwd_vld_o=0.
REQ-022 SHALL leave entry payload and mem_addr/data/bm/io unreset; reset mid-request SHALL drop the request with no ack expected.

Configuration
REQ-023 SHALL use macro STORE_BUFFER_FWD_EN. Defined: find the youngest matching overlapping entry; if its bm covers conflict_bm_i ((bm & conflict_bm_i) == conflict_bm_i) and it is not io, drive fwd_vld_o=1, fwd_data_o=its data and conflict_o=0. Undefined: fwd_vld_o=0, fwd_data_o=0, conflict_o per REQ-018.

Verification
REQ-024 SHALL cover: reset, enqueue 8 stores (DEPTH=8) with no commit -> enqueue_full_o=1 after the 8th; a 9th enqueue is ignored; tail-head stays 8.
REQ-025 SHALL cover: enqueue addr 0x10 data 0xAABBCCDD bm 1111, commit_i, ack in the 3rd REQ cycle -> mem_addr_o=0x10, mem_data_o=0xAABBCCDD held 3 cycles; then sb_empty_o=1.
REQ-026 SHALL cover: enqueue A,B,C; commit A; flush_i -> B and C removed (tail=cmt=1); A still drains; later enqueue reuses slot 1.
REQ-027 SHALL cover: commit_i and flush_i in the same cycle with 2 uncommitted entries -> one entry survives and drains.
REQ-028 SHALL cover: entry addr 0x20 bm 0011 data 0x00001234; probe 0x20 bm 0001 -> FWD_EN: fwd_vld_o=1, fwd_data_o=0x00001234, conflict_o=0; else conflict_o=1; probe bm 1100 -> conflict_o=0 both builds.
REQ-029 SHALL cover: wrap-around, 20 enqueue/commit/drain cycles with random ack delay 0..3 -> stores reach memory in program order and none is lost.
